// File: rtl/halt_sequencer.sv
// Program counter and three-phase instruction sequencer (FETCH/DECODE/EXEC)
// running under halt_handler's run enable; HALT opcodes raise a halt request.
module halt_sequencer #(
   parameter int          ADDR_W  = 4,
   parameter int          DATA_W  = 8,
   parameter logic [3:0]  HALT_OP = 4'hF,
   parameter logic [3:0]  JMP_OP  = 4'hE,
   parameter int          CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc,
   output logic              halt_req,
   output logic              halted,
   output logic [CNT_W-1:0]  instr_count
);

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   instr_q, instr_d;
   logic                halted_q, halted_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                run_en_d_q;
   logic [3:0]          opcode_s;

   localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   assign opcode_s = instr_q[DATA_W-1 -: 4];

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_FETCH;
         pc_q       <= {ADDR_W{1'b0}};
         instr_q    <= {DATA_W{1'b0}};
         halted_q   <= 1'b0;
         cnt_q      <= {CNT_W{1'b0}};
         run_en_d_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         halted_q   <= halted_d;
         cnt_q      <= cnt_d;
         run_en_d_q <= run_en;
      end
   end

   // Next-state and datapath update; everything outside HALTED is gated by run_en
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      halted_d = halted_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_FETCH: begin
            if (run_en) state_d = ST_DECODE;
            else        state_d = state_q;
         end
         ST_DECODE: begin
            if (run_en) begin
               instr_d = imem_data;
               state_d = ST_EXEC;
            end else begin
               state_d = state_q;
            end
         end
         ST_EXEC: begin
            if (run_en) begin
               cnt_d = cnt_q + CNT_ONE;
               if (opcode_s == HALT_OP) begin
                  pc_d     = pc_q + PC_ONE;
                  halted_d = 1'b1;
                  state_d  = ST_HALTED;
               end else if (opcode_s == JMP_OP) begin
                  pc_d    = instr_q[ADDR_W-1:0];
                  state_d = ST_FETCH;
               end else begin
                  pc_d    = pc_q + PC_ONE;
                  state_d = ST_FETCH;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_HALTED: begin
            // Resume needs a fresh 0->1 on run_en, not a level left over from the halt
            if (run_en && !run_en_d_q) begin
               halted_d = 1'b0;
               state_d  = ST_FETCH;
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // Output decode of the EXEC state
   always_comb begin
      instr_valid = 1'b0;
      halt_req    = 1'b0;
      if ((state_q == ST_EXEC) && run_en) begin
         instr_valid = 1'b1;
         halt_req    = (opcode_s == HALT_OP);
      end else begin
         instr_valid = 1'b0;
         halt_req    = 1'b0;
      end
   end

   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign halted      = halted_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_halt_sequencer.sv
// Directed bench for halt_sequencer: per-cycle vector tables plus hand-written
// sequences for counter wrap and reset during a halt request.
module tb_halt_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       run_en;
   logic [3:0] imem_addr;
   logic [7:0] imem_data;
   logic [7:0] instr;
   logic       instr_valid;
   logic [3:0] pc;
   logic       halt_req;
   logic       halted;
   logic [7:0] instr_count;

   logic [7:0] mem [16];

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       run;
      logic [3:0] pc;
      logic [7:0] instr;
      logic       iv;
      logic       hr;
      logic       hlt;
      logic [7:0] cnt;
   } vec_t;

   vec_t vq[$];

   halt_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .run_en     (run_en),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .instr      (instr),
      .instr_valid(instr_valid),
      .pc         (pc),
      .halt_req   (halt_req),
      .halted     (halted),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_data <= mem[imem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] p, input logic [7:0] i,
                      input logic v, input logic h, input logic hl, input logic [7:0] c);
      vec_t e;
      e.run = r; e.pc = p; e.instr = i; e.iv = v; e.hr = h; e.hlt = hl; e.cnt = c;
      vq.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic run_vectors(input string tag);
      for (int i = 0; i < vq.size(); i++) begin
         run_en = vq[i].run;
         #1;
         chk($sformatf("%s[%0d].pc", tag, i), {28'd0, pc}, {28'd0, vq[i].pc});
         chk($sformatf("%s[%0d].addr", tag, i), {28'd0, imem_addr}, {28'd0, vq[i].pc});
         chk($sformatf("%s[%0d].instr", tag, i), {24'd0, instr}, {24'd0, vq[i].instr});
         chk($sformatf("%s[%0d].iv", tag, i), {31'd0, instr_valid}, {31'd0, vq[i].iv});
         chk($sformatf("%s[%0d].hr", tag, i), {31'd0, halt_req}, {31'd0, vq[i].hr});
         chk($sformatf("%s[%0d].halted", tag, i), {31'd0, halted}, {31'd0, vq[i].hlt});
         chk($sformatf("%s[%0d].cnt", tag, i), {24'd0, instr_count}, {24'd0, vq[i].cnt});
         @(posedge clk);
         #1;
      end
      vq.delete();
   endtask

   task automatic clear_mem(input logic [7:0] v);
      for (int a = 0; a < 16; a++) mem[a] = v;
   endtask

   initial begin
      int n;
      int cyc;
      rst = 1'b1;
      run_en = 1'b0;
      clear_mem(8'h00);

      // Program 1: straight line to HALT, held-high run_en, resume on rising edge
      mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'hF0; mem[3] = 8'h03;
      rst = 1'b1;
      #1;
      chk("reset.pc", {28'd0, pc}, 32'd0);
      chk("reset.halted", {31'd0, halted}, 32'd0);
      chk("reset.cnt", {24'd0, instr_count}, 32'd0);
      do_reset();
      add(1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
      add(1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
      add(1'b1, 4'd0, 8'h01, 1'b1, 1'b0, 1'b0, 8'd0);
      add(1'b1, 4'd1, 8'h01, 1'b0, 1'b0, 1'b0, 8'd1);
      add(1'b1, 4'd1, 8'h01, 1'b0, 1'b0, 1'b0, 8'd1);
      add(1'b1, 4'd1, 8'h02, 1'b1, 1'b0, 1'b0, 8'd1);
      add(1'b1, 4'd2, 8'h02, 1'b0, 1'b0, 1'b0, 8'd2);
      add(1'b1, 4'd2, 8'h02, 1'b0, 1'b0, 1'b0, 8'd2);
      add(1'b1, 4'd2, 8'hF0, 1'b1, 1'b1, 1'b0, 8'd2);
      for (int k = 0; k < 10; k++) add(1'b1, 4'd3, 8'hF0, 1'b0, 1'b0, 1'b1, 8'd3);
      add(1'b0, 4'd3, 8'hF0, 1'b0, 1'b0, 1'b1, 8'd3);
      add(1'b0, 4'd3, 8'hF0, 1'b0, 1'b0, 1'b1, 8'd3);
      add(1'b1, 4'd3, 8'hF0, 1'b0, 1'b0, 1'b1, 8'd3);
      add(1'b1, 4'd3, 8'hF0, 1'b0, 1'b0, 1'b0, 8'd3);
      add(1'b1, 4'd3, 8'hF0, 1'b0, 1'b0, 1'b0, 8'd3);
      add(1'b1, 4'd3, 8'h03, 1'b1, 1'b0, 1'b0, 8'd3);
      add(1'b1, 4'd4, 8'h03, 1'b0, 1'b0, 1'b0, 8'd4);
      run_vectors("halt_resume");

      // Program 2: JMP to 5 then HALT
      clear_mem(8'h00);
      mem[0] = 8'hE5; mem[5] = 8'hF0;
      do_reset();
      add(1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
      add(1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
      add(1'b1, 4'd0, 8'hE5, 1'b1, 1'b0, 1'b0, 8'd0);
      add(1'b1, 4'd5, 8'hE5, 1'b0, 1'b0, 1'b0, 8'd1);
      add(1'b1, 4'd5, 8'hE5, 1'b0, 1'b0, 1'b0, 8'd1);
      add(1'b1, 4'd5, 8'hF0, 1'b1, 1'b1, 1'b0, 8'd1);
      add(1'b1, 4'd6, 8'hF0, 1'b0, 1'b0, 1'b1, 8'd2);
      run_vectors("jmp");

      // Program 3: run_en gaps in DECODE and in EXEC
      clear_mem(8'h01);
      do_reset();
      add(1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
      for (int k = 0; k < 4; k++) add(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
      add(1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
      add(1'b0, 4'd0, 8'h01, 1'b0, 1'b0, 1'b0, 8'd0);
      add(1'b1, 4'd0, 8'h01, 1'b1, 1'b0, 1'b0, 8'd0);
      add(1'b1, 4'd1, 8'h01, 1'b0, 1'b0, 1'b0, 8'd1);
      run_vectors("gap");

      // Program 4: all NOPs, pc and instr_count wrap, never a halt request
      clear_mem(8'h01);
      do_reset();
      run_en = 1'b1;
      n = 0;
      cyc = 0;
      while (n < 256 && cyc < 1000) begin
         #1;
         if (halt_req) chk("wrap.no_halt", {31'd0, halt_req}, 32'd0);
         if (instr_valid) begin
            if (n % 37 == 0 || n >= 254)
               chk($sformatf("wrap.pc%0d", n), {28'd0, pc}, n % 16);
            if (n == 255) chk("wrap.cnt255", {24'd0, instr_count}, 32'd255);
            n++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("wrap.done", n, 32'd256);
      #1;
      chk("wrap.cnt0", {24'd0, instr_count}, 32'd0);
      chk("wrap.pc0", {28'd0, pc}, 32'd0);

      // Program 5: reset asserted during the HALT execute cycle
      clear_mem(8'h00);
      mem[0] = 8'hF0;
      do_reset();
      run_en = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst.hr_before", {31'd0, halt_req}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst.hr_cut", {31'd0, halt_req}, 32'd0);
      chk("rst.iv", {31'd0, instr_valid}, 32'd0);
      chk("rst.instr", {24'd0, instr}, 32'd0);
      chk("rst.halted", {31'd0, halted}, 32'd0);
      chk("rst.cnt", {24'd0, instr_count}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      add(1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
      add(1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
      add(1'b1, 4'd0, 8'hF0, 1'b1, 1'b1, 1'b0, 8'd0);
      add(1'b1, 4'd1, 8'hF0, 1'b0, 1'b0, 1'b1, 8'd1);
      run_vectors("rst_restart");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
